mips_cycle_sequencer: RTL and testbench

//   Multi-cycle control FSM for the MIPS core: drives the one-hot FETCH/EXEC1/EXEC2 phase

---
 rtl/mips_cycle_sequencer_if.sv | 30 +++
 rtl/mips_cycle_sequencer.sv | 92 +++++++++
 tb/tb_mips_cycle_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cycle_sequencer_if.sv
// Control bundle between the cycle sequencer and the datapath/memory it steers.
// The sequencer owns the master side; the datapath and bus status live on the slave side.
interface mips_cycle_sequencer_if;
  logic waitrequest;
  logic pc_halt;
  logic exec2_required;
  logic exec1_mem_read;
  logic exec1_mem_write;
  logic rd_write_req;
  logic fetch;
  logic exec1;
  logic exec2;
  logic ir_en;
  logic pc_en;
  logic reg_wen;
  logic mem_read;
  logic mem_write;
  logic active;
  logic bus_error;

  modport master (
    input  waitrequest, pc_halt, exec2_required, exec1_mem_read, exec1_mem_write, rd_write_req,
    output fetch, exec1, exec2, ir_en, pc_en, reg_wen, mem_read, mem_write, active, bus_error
  );

  modport slave (
    output waitrequest, pc_halt, exec2_required, exec1_mem_read, exec1_mem_write, rd_write_req,
    input  fetch, exec1, exec2, ir_en, pc_en, reg_wen, mem_read, mem_write, active, bus_error
  );
endinterface

// File: rtl/mips_cycle_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2 control FSM with waitrequest stretching,
// halt detection and a sticky bus-timeout error.
module mips_cycle_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  mips_cycle_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC1, S_EXEC2, S_HALTED} state_t;

  localparam bit              LIMIT_ON = (WAIT_LIMIT != 0);
  // Timeout fires on the stalled cycle that would bring the count to WAIT_LIMIT.
  localparam logic [WAIT_W-1:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              bus_error_q;
  logic              req, stall, timeout;

  always_comb begin
    bus.fetch     = 1'b0;
    bus.exec1     = 1'b0;
    bus.exec2     = 1'b0;
    bus.ir_en     = 1'b0;
    bus.pc_en     = 1'b0;
    bus.reg_wen   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    req           = 1'b0;
    state_nxt     = state;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          bus.fetch = 1'b1;
          if (bus.pc_halt) begin
            state_nxt = S_HALTED;
          end else begin
            bus.mem_read = 1'b1;
            req          = 1'b1;
            if (!bus.waitrequest) begin
              bus.ir_en = 1'b1;
              state_nxt = S_EXEC1;
            end
          end
        end
        S_EXEC1: begin
          bus.exec1     = 1'b1;
          bus.mem_write = bus.exec1_mem_write;
          bus.mem_read  = bus.exec1_mem_read & ~bus.exec1_mem_write;
          req           = bus.exec1_mem_read | bus.exec1_mem_write;
          if (!(req && bus.waitrequest)) begin
            if (bus.exec2_required) begin
              state_nxt = S_EXEC2;
            end else begin
              bus.pc_en   = 1'b1;
              bus.reg_wen = bus.rd_write_req;
              state_nxt   = S_FETCH;
            end
          end
        end
        S_EXEC2: begin
          bus.exec2   = 1'b1;
          bus.pc_en   = 1'b1;
          bus.reg_wen = bus.rd_write_req;
          state_nxt   = S_FETCH;
        end
        default: state_nxt = S_HALTED;
      endcase
    end
    stall   = req & bus.waitrequest;
    timeout = LIMIT_ON && stall && (wait_cnt >= LIMIT_M1);
    // Stalled cycles never raise enables, so redirecting the state is enough here.
    if (timeout) state_nxt = S_HALTED;
    bus.active    = !reset && (state != S_HALTED);
    bus.bus_error = bus_error_q & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!stall)                          wait_cnt <= '0;
      else if (wait_cnt != {WAIT_W{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      if (timeout) bus_error_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Directed bench for mips_cycle_sequencer: a phase-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_mips_cycle_sequencer;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mips_cycle_sequencer_if ifc();

  mips_cycle_sequencer #(.WAIT_LIMIT(LIM), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {ifc.fetch, ifc.exec1, ifc.exec2, ifc.ir_en, ifc.pc_en, ifc.reg_wen,
                 ifc.mem_read, ifc.mem_write, ifc.active, ifc.bus_error};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0=FETCH 1=EXEC1 2=EXEC2 3=HALTED, plus run length of stalls.
  int m_ph = 0;
  int m_waits = 0;
  bit m_err = 1'b0;

  always @(negedge clk) begin
    bit f, e1, e2, ir, pc, rw, mr, mw, act, be, req, stl;
    int nx;
    f = 0; e1 = 0; e2 = 0; ir = 0; pc = 0; rw = 0; mr = 0; mw = 0; act = 0; be = 0; req = 0;
    if (reset) begin
      m_ph = 0; m_waits = 0; m_err = 1'b0;
      chk("cycle_model", {22'd0, outs}, 32'd0);
    end else begin
      be  = m_err;
      act = (m_ph != 3);
      nx  = m_ph;
      if (m_ph == 0) begin
        f = 1;
        if (!ifc.pc_halt) begin mr = 1; req = 1; end
      end else if (m_ph == 1) begin
        e1 = 1;
        mw = ifc.exec1_mem_write;
        mr = ifc.exec1_mem_read && !ifc.exec1_mem_write;
        req = ifc.exec1_mem_read || ifc.exec1_mem_write;
      end else if (m_ph == 2) begin
        e2 = 1;
      end
      stl = req && ifc.waitrequest;
      if (m_ph == 0 && ifc.pc_halt) nx = 3;
      else if (m_ph == 0 && !stl) begin ir = 1; nx = 1; end
      else if (m_ph == 1 && !stl) begin
        if (ifc.exec2_required) nx = 2;
        else begin pc = 1; rw = ifc.rd_write_req; nx = 0; end
      end else if (m_ph == 2) begin
        pc = 1; rw = ifc.rd_write_req; nx = 0;
      end
      m_waits = stl ? m_waits + 1 : 0;
      if (stl && m_waits >= LIM) begin m_err = 1'b1; nx = 3; end
      chk("cycle_model", {22'd0, outs}, {22'd0, f, e1, e2, ir, pc, rw, mr, mw, act, be});
      m_ph = nx;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifc.waitrequest = 0; ifc.pc_halt = 0; ifc.exec2_required = 0;
    ifc.exec1_mem_read = 0; ifc.exec1_mem_write = 0; ifc.rd_write_req = 0;
    #3;
    chk("reset_outs", {22'd0, outs}, 32'd0);
    cyc(); cyc();

    // 1: plain ALU instructions back to back
    reset = 1'b0; ifc.rd_write_req = 1;
    for (int k = 1; k <= 6; k++) begin
      #2;
      chk("t1_fetch", ifc.fetch, k % 2);
      chk("t1_ir_en", ifc.ir_en, k % 2);
      chk("t1_pc_en", ifc.pc_en, (k % 2) == 0);
      chk("t1_reg_wen", ifc.reg_wen, (k % 2) == 0);
      cyc();
    end

    // 2: fetch stretched by three wait cycles
    for (int i = 0; i < 4; i++) begin
      ifc.waitrequest = (i < 3);
      #2;
      chk("t2_fetch", ifc.fetch, 1);
      chk("t2_mem_read", ifc.mem_read, 1);
      chk("t2_ir_en", ifc.ir_en, i == 3);
      cyc();
    end
    ifc.waitrequest = 1;  // EXEC1 without access ignores waitrequest
    #2;
    chk("t2_exec1_pc_en", ifc.pc_en, 1);
    cyc();

    // 3: load with two stalled EXEC1 cycles, then EXEC2
    ifc.waitrequest = 0; ifc.exec1_mem_read = 1; ifc.exec2_required = 1;
    #2; chk("t3_ir_en", ifc.ir_en, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      ifc.waitrequest = (i < 2);
      #2;
      chk("t3_exec1", ifc.exec1, 1);
      chk("t3_mem_read", ifc.mem_read, 1);
      chk("t3_pc_en", ifc.pc_en, 0);
      chk("t3_reg_wen", ifc.reg_wen, 0);
      cyc();
    end
    ifc.waitrequest = 1;
    #2;
    chk("t3_exec2", ifc.exec2, 1);
    chk("t3_exec2_en", {ifc.pc_en, ifc.reg_wen, ifc.mem_read}, 3'b110);
    cyc();

    // 4: write wins over read
    ifc.waitrequest = 0; ifc.exec1_mem_write = 1; ifc.exec2_required = 0;
    cyc();
    #2;
    chk("t4_rw", {ifc.exec1, ifc.mem_write, ifc.mem_read, ifc.pc_en}, 4'b1101);
    cyc();
    ifc.exec1_mem_read = 0; ifc.exec1_mem_write = 0;

    // 5: halt at fetch
    ifc.pc_halt = 1;
    #2;
    chk("t5_halt_fetch", {ifc.fetch, ifc.mem_read, ifc.active}, 3'b101);
    cyc();
    ifc.pc_halt = 0; ifc.waitrequest = 1;
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("t5_halted", {22'd0, outs}, 32'd0);
      cyc();
    end

    // 6: stall, reset mid-stall, then timeout
    reset = 1; cyc();
    reset = 0;
    for (int i = 0; i < 2; i++) begin #2; chk("t6_stall_a", ifc.fetch, 1); cyc(); end
    reset = 1;
    #2; chk("t6_mid_reset", {22'd0, outs}, 32'd0);
    cyc();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t6_stall_b", {ifc.fetch, ifc.ir_en, ifc.active, ifc.bus_error}, 4'b1010);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("t6_timeout", {ifc.fetch, ifc.active, ifc.bus_error}, 3'b001);
      cyc();
    end
    reset = 1;
    #2; chk("t6_reset_err", {22'd0, outs}, 32'd0);
    cyc();
    reset = 0; ifc.waitrequest = 0;
    #2;
    chk("t6_restart", {ifc.fetch, ifc.ir_en, ifc.active, ifc.bus_error}, 4'b1110);
    cyc();
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
